// File: rtl/ofdm_pkg.sv
// Shared OFDM receive-path constants: modulation encodings, bits per symbol,
// hard-decision slicer thresholds and the demapper FIFO word layout.
package ofdm_pkg;

   typedef enum logic [1:0] {
      MAP_BPSK  = 2'b00,
      MAP_QPSK  = 2'b01,
      MAP_QAM16 = 2'b10,
      MAP_QAM64 = 2'b11
   } map_type_e;

   localparam logic [2:0] BPT_BPSK  = 3'd1;
   localparam logic [2:0] BPT_QPSK  = 3'd2;
   localparam logic [2:0] BPT_QAM16 = 3'd4;
   localparam logic [2:0] BPT_QAM64 = 3'd6;

   localparam logic [6:0] THR_QAM16     = 7'd40;
   localparam logic [6:0] THR_QAM64_LO  = 7'd19;
   localparam logic [6:0] THR_QAM64_MID = 7'd39;
   localparam logic [6:0] THR_QAM64_HI  = 7'd59;

   localparam logic [1:0] FIFO_DEPTH = 2'd2;

   // One buffered symbol: its modulation and up to six sliced bits, b0 in bit 0.
   typedef struct packed {
      map_type_e  mtype;
      logic [5:0] bits;
   } demap_word_t;

   function automatic logic [2:0] bits_per_type(input map_type_e t);
      case (t)
         MAP_BPSK:  return BPT_BPSK;
         MAP_QPSK:  return BPT_QPSK;
         MAP_QAM16: return BPT_QAM16;
         default:   return BPT_QAM64;
      endcase
   endfunction

   // |x| of a Q1.6 sample; -128 has no positive twin and saturates to 127.
   function automatic logic [6:0] mag_sat(input logic [7:0] x);
      logic [7:0] neg;
      neg = ~x + 8'd1;
      if (x == 8'h80) return 7'd127;
      if (x[7])       return neg[6:0];
      return x[6:0];
   endfunction

endpackage

// File: rtl/data_demapping_if.sv
// Sample-in / bit-out handshake bundle of the constellation demapper.
interface data_demapping_if;
   import ofdm_pkg::*;

   map_type_e  map_type;
   logic [7:0] in_re;
   logic [7:0] in_im;
   logic       in_vld;
   logic       in_rdy;
   logic       dout;
   logic       dout_vld;
   logic       dout_rdy;
   logic       bit_last;

   modport slave (
      input  map_type, in_re, in_im, in_vld, dout_rdy,
      output in_rdy, dout, dout_vld, bit_last
   );

   modport master (
      output map_type, in_re, in_im, in_vld, dout_rdy,
      input  in_rdy, dout, dout_vld, bit_last
   );

endinterface

// File: rtl/demap_fifo2.sv
// Two-entry synchronous FIFO, 8 bits wide, with full/empty flags, occupancy
// count and synchronous clear. Writes when full and reads when empty are ignored.
module demap_fifo2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       wr_en_i,
   input  logic [7:0] wr_data_i,
   input  logic       rd_en_i,
   output logic [7:0] rd_data_o,
   output logic       full_o,
   output logic       empty_o,
   output logic [1:0] count_o
);

   logic [7:0] mem_q [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic       do_wr, do_rd;

   assign full_o    = (count_q == 2'd2);
   assign empty_o   = (count_q == 2'd0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   assign do_wr = wr_en_i && !full_o && !clr_i;
   assign do_rd = rd_en_i && !empty_o && !clr_i;

   // NOTE: every next-state variable is given its current value first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_wr) wr_ptr_d = ~wr_ptr_q;
         if (do_rd) rd_ptr_d = ~rd_ptr_q;
         case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; an entry is only ever read after it has been written.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/data_demapping.sv
// Hard-decision BPSK/QPSK/16-QAM/64-QAM demapper: slicer, 2-entry FIFO, bit
// serializer. Optional sym_cnt output is built when DEMAP_STAT_EN is defined.
module data_demapping
   import ofdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_clr,
   data_demapping_if.slave   bus
`ifdef DEMAP_STAT_EN
   ,
   output logic [15:0]       sym_cnt
`endif
);

   logic        s_re, s_im;
   logic [6:0]  mag_re, mag_im;
   logic [5:0]  slice_bits;
   demap_word_t wr_word;

   logic        fifo_wr_en;
   logic        fifo_rd_en;
   logic [7:0]  fifo_rd_data;
   logic        fifo_full;
   logic        fifo_empty;
   logic [1:0]  fifo_count;

   demap_word_t word_q, word_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        vld_q, vld_d;
   logic        last_bit;
   logic        consume;
   logic        load;

   // Slicer: sign is 1 for x >= 0, so zero decodes as the positive point.
   assign s_re   = ~bus.in_re[7];
   assign s_im   = ~bus.in_im[7];
   assign mag_re = mag_sat(bus.in_re);
   assign mag_im = mag_sat(bus.in_im);

   always_comb begin
      slice_bits = 6'd0;
      case (bus.map_type)
         MAP_BPSK: begin
            slice_bits[0] = s_re;
         end
         MAP_QPSK: begin
            slice_bits[0] = s_re;
            slice_bits[1] = s_im;
         end
         MAP_QAM16: begin
            slice_bits[0] = (mag_re < THR_QAM16);
            slice_bits[1] = s_re;
            slice_bits[2] = (mag_im < THR_QAM16);
            slice_bits[3] = s_im;
         end
         default: begin
            slice_bits[0] = (mag_re >= THR_QAM64_LO) && (mag_re < THR_QAM64_HI);
            slice_bits[1] = (mag_re < THR_QAM64_MID);
            slice_bits[2] = s_re;
            slice_bits[3] = (mag_im >= THR_QAM64_LO) && (mag_im < THR_QAM64_HI);
            slice_bits[4] = (mag_im < THR_QAM64_MID);
            slice_bits[5] = s_im;
         end
      endcase
   end

   assign wr_word.mtype = bus.map_type;
   assign wr_word.bits  = slice_bits;

   assign bus.in_rdy = (fifo_count < FIFO_DEPTH);
   assign fifo_wr_en = bus.in_vld && !fifo_full && !rx_clr;

   demap_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (rx_clr),
      .wr_en_i   (fifo_wr_en),
      .wr_data_i (wr_word),
      .rd_en_i   (fifo_rd_en),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   // Serializer reloads on the edge that consumes its last bit, so symbols follow without a gap.
   assign last_bit   = vld_q && (cnt_q == (bits_per_type(word_q.mtype) - 3'd1));
   assign consume    = vld_q && bus.dout_rdy;
   assign load       = !fifo_empty && !rx_clr && (!vld_q || (consume && last_bit));
   assign fifo_rd_en = load;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      if (rx_clr) begin
         cnt_d = 3'd0;
         vld_d = 1'b0;
      end else if (load) begin
         word_d = demap_word_t'(fifo_rd_data);
         cnt_d  = 3'd0;
         vld_d  = 1'b1;
      end else if (consume) begin
         if (last_bit) begin
            cnt_d = 3'd0;
            vld_d = 1'b0;
         end else begin
            word_d.bits = {1'b0, word_q.bits[5:1]};
            cnt_d       = cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         cnt_q  <= 3'd0;
         vld_q  <= 1'b0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end

   assign bus.dout     = vld_q & word_q.bits[0];
   assign bus.dout_vld = vld_q;
   assign bus.bit_last = last_bit;

`ifdef DEMAP_STAT_EN
   logic [15:0] sym_cnt_q, sym_cnt_d;

   always_comb begin
      sym_cnt_d = sym_cnt_q;
      if (rx_clr)
         sym_cnt_d = 16'd0;
      else if (bus.in_vld && bus.in_rdy && (sym_cnt_q != 16'hFFFF))
         sym_cnt_d = sym_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sym_cnt_q <= 16'd0;
      else        sym_cnt_q <= sym_cnt_d;
   end

   assign sym_cnt = sym_cnt_q;
`endif

endmodule

// File: tb/tb_data_demapping.sv
// Self-checking bench for data_demapping: directed cases with literal
// expectations plus randomized traffic scored against a bit-queue model.
module tb_data_demapping;
   import ofdm_pkg::*;

   logic clk;
   logic rst_n;
   logic rx_clr;

   data_demapping_if bus ();

`ifdef DEMAP_STAT_EN
   logic [15:0] sym_cnt;
   int          exp_sym;
`endif

   data_demapping dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .rx_clr (rx_clr),
      .bus    (bus)
`ifdef DEMAP_STAT_EN
      ,
      .sym_cnt(sym_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit b;
      bit l;
   } exp_bit_t;

   exp_bit_t exp_q[$];
   int       n_cmp;
   int       n_err;
   int       bits_seen;
   bit       stalled_prev;
   bit       prev_dout;
   bit       prev_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference slicing written straight from the constellation rules.
   task automatic push_model(input logic [1:0] mt, input logic [7:0] re, input logic [7:0] im);
      int r, i, ar, ai;
      r  = int'($signed(re));
      i  = int'($signed(im));
      ar = (r < 0) ? -r : r;
      ai = (i < 0) ? -i : i;
      if (ar > 127) ar = 127;
      if (ai > 127) ai = 127;
      case (mt)
         2'b00: exp_q.push_back('{b: (r >= 0), l: 1'b1});
         2'b01: begin
            exp_q.push_back('{b: (r >= 0), l: 1'b0});
            exp_q.push_back('{b: (i >= 0), l: 1'b1});
         end
         2'b10: begin
            exp_q.push_back('{b: (ar < 40), l: 1'b0});
            exp_q.push_back('{b: (r >= 0),  l: 1'b0});
            exp_q.push_back('{b: (ai < 40), l: 1'b0});
            exp_q.push_back('{b: (i >= 0),  l: 1'b1});
         end
         default: begin
            exp_q.push_back('{b: (ar >= 19 && ar < 59), l: 1'b0});
            exp_q.push_back('{b: (ar < 39),             l: 1'b0});
            exp_q.push_back('{b: (r >= 0),              l: 1'b0});
            exp_q.push_back('{b: (ai >= 19 && ai < 59), l: 1'b0});
            exp_q.push_back('{b: (ai < 39),             l: 1'b0});
            exp_q.push_back('{b: (i >= 0),              l: 1'b1});
         end
      endcase
   endtask

   // Compare process: outputs are sampled on the falling edge, midway between active edges.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         stalled_prev = 1'b0;
`ifdef DEMAP_STAT_EN
         exp_sym = 0;
`endif
      end else begin
         if (stalled_prev) begin
            check("stall_vld_hold", bus.dout_vld, 1'b1);
            check("stall_dout_hold", bus.dout, prev_dout);
            check("stall_last_hold", bus.bit_last, prev_last);
         end
         if (bus.dout_vld) begin
            check("vld_with_bits_pending", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
               check("dout", bus.dout, exp_q[0].b);
               check("bit_last", bus.bit_last, exp_q[0].l);
               if (bus.dout_rdy && !rx_clr) begin
                  void'(exp_q.pop_front());
                  bits_seen++;
               end
            end
         end else begin
            check("bit_last_idle", bus.bit_last, 1'b0);
         end
         stalled_prev = bus.dout_vld && !bus.dout_rdy && !rx_clr;
         prev_dout    = bus.dout;
         prev_last    = bus.bit_last;
         if (rx_clr) begin
            exp_q.delete();
`ifdef DEMAP_STAT_EN
            exp_sym = 0;
`endif
         end else if (bus.in_vld && bus.in_rdy) begin
            push_model(bus.map_type, bus.in_re, bus.in_im);
`ifdef DEMAP_STAT_EN
            if (exp_sym < 65535) exp_sym++;
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [1:0] mt, input logic [7:0] re, input logic [7:0] im);
      bus.map_type = map_type_e'(mt);
      bus.in_re    = re;
      bus.in_im    = im;
   endtask

   // Offers one sample and returns in the cycle after it is accepted.
   task automatic send(input logic [1:0] mt, input logic [7:0] re, input logic [7:0] im);
      bit acc;
      set_in(mt, re, im);
      bus.in_vld = 1'b1;
      for (int t = 0; t < 200; t++) begin
         acc = bus.in_rdy && !rx_clr;
         step();
         if (acc) begin
            bus.in_vld = 1'b0;
            return;
         end
      end
      bus.in_vld = 1'b0;
      check("send_timeout", 1'b1, 1'b0);
   endtask

   // Checks n consecutive output bits, one per cycle, starting in the current cycle.
   task automatic expect_bits(input string name, input logic [5:0] bits, input int n);
      logic [5:0] b;
      b = bits;
      for (int k = 0; k < n; k++) begin
         check({name, "_vld"}, bus.dout_vld, 1'b1);
         check({name, "_bit"}, bus.dout, b[k]);
         check({name, "_last"}, bus.bit_last, (k == n - 1));
         step();
      end
      check({name, "_vld_drop"}, bus.dout_vld, 1'b0);
   endtask

   task automatic drain(input string name);
      bus.in_vld   = 1'b0;
      bus.dout_rdy = 1'b1;
      for (int t = 0; t < 300; t++) begin
         if (exp_q.size() == 0 && !bus.dout_vld) break;
         step();
      end
      check({name, "_queue_empty"}, exp_q.size(), 0);
      check({name, "_idle"}, bus.dout_vld, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int base;
      int j;
      bit acc;
      logic [7:0] bp_re [5];
      logic [7:0] bp_im [5];
      logic [1:0] mt;

      n_cmp = 0;
      n_err = 0;
      bits_seen = 0;
      rst_n = 1'b0;
      rx_clr = 1'b0;
      bus.in_vld = 1'b0;
      bus.dout_rdy = 1'b1;
      set_in(2'b00, 8'h00, 8'h00);

      repeat (3) step();
      check("rst_dout", bus.dout, 1'b0);
      check("rst_dout_vld", bus.dout_vld, 1'b0);
      check("rst_bit_last", bus.bit_last, 1'b0);
      check("rst_in_rdy", bus.in_rdy, 1'b1);
`ifdef DEMAP_STAT_EN
      check("rst_sym_cnt", sym_cnt, 16'd0);
`endif
      rst_n = 1'b1;
      step();

      // 16-QAM single sample: accepted in N, first bit visible in N+2.
      send(2'b10, 8'h3D, 8'hEC);
      check("qam16_latency_n1", bus.dout_vld, 1'b0);
      step();
      expect_bits("qam16", 6'b000110, 4);

      send(2'b11, 8'h45, 8'hF7);
      step();
      expect_bits("qam64", 6'b010100, 6);

      // BPSK back-to-back: one sample and one bit every cycle.
      begin
         logic [7:0] bre [4];
         logic [3:0] bexp;
         bre[0] = 8'h40; bre[1] = 8'hC0; bre[2] = 8'h40; bre[3] = 8'h00;
         bexp = 4'b1101;
         for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
               set_in(2'b00, bre[k], 8'h00);
               bus.in_vld = 1'b1;
               check("bpsk_in_rdy", bus.in_rdy, 1'b1);
            end else begin
               bus.in_vld = 1'b0;
            end
            if (k >= 2) begin
               check("bpsk_vld", bus.dout_vld, 1'b1);
               check("bpsk_bit", bus.dout, bexp[k-2]);
               check("bpsk_last", bus.bit_last, 1'b1);
            end
            step();
         end
         drain("bpsk");
      end

      // Backpressure: five 16-QAM samples, downstream stalled for 12 cycles.
      for (int k = 0; k < 5; k++) begin
         bp_re[k] = 8'($urandom);
         bp_im[k] = 8'($urandom);
      end
      base = bits_seen;
      bus.dout_rdy = 1'b0;
      j = 0;
      for (int c = 0; c < 12; c++) begin
         set_in(2'b10, bp_re[j], bp_im[j]);
         bus.in_vld = 1'b1;
         acc = bus.in_rdy;
         step();
         if (acc) j++;
      end
      check("bp_held_count", j, 3);
      check("bp_in_rdy_low", bus.in_rdy, 1'b0);
      bus.dout_rdy = 1'b1;
      for (int t = 0; t < 200 && j < 5; t++) begin
         set_in(2'b10, bp_re[j], bp_im[j]);
         bus.in_vld = 1'b1;
         acc = bus.in_rdy;
         step();
         if (acc) j++;
      end
      check("bp_all_accepted", j, 5);
      drain("bp");
      check("bp_bit_total", bits_seen - base, 20);

      // Flush two bits into a 64-QAM symbol, then a QPSK symbol.
      send(2'b11, 8'($urandom), 8'($urandom));
      step();
      step();
      rx_clr = 1'b1;
      check("clr_vld_before", bus.dout_vld, 1'b1);
      step();
      rx_clr = 1'b0;
      check("clr_vld_after", bus.dout_vld, 1'b0);
      check("clr_in_rdy", bus.in_rdy, 1'b1);
      send(2'b01, 8'h2D, 8'hD3);
      step();
      expect_bits("qpsk_after_clr", 6'b000001, 2);

      send(2'b10, 8'h80, 8'h7F);
      step();
      expect_bits("saturation", 6'b001000, 4);

      // Randomized traffic with mid-stream type changes, stalls and flushes.
      for (int c = 0; c < 3000; c++) begin
         mt = 2'($urandom_range(0, 3));
         set_in(mt, 8'($urandom), 8'($urandom));
         bus.in_vld   = ($urandom_range(0, 3) != 0);
         bus.dout_rdy = ($urandom_range(0, 3) != 0);
         rx_clr       = ($urandom_range(0, 59) == 0);
         step();
      end
      rx_clr = 1'b0;
      drain("random");
`ifdef DEMAP_STAT_EN
      check("sym_cnt", sym_cnt, 16'(exp_sym));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
